// File: rtl/connect6_pkg.sv
// Shared Connect Six definitions: FSM encoding, player colours, board defaults
// and turn-size constants.
package connect6_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam logic PLAYER_BLACK = 1'b0;
  localparam logic PLAYER_WHITE = 1'b1;

  localparam int unsigned DEFAULT_BOARD_SIZE = 19;
  localparam int unsigned DEFAULT_COORD_W    = 5;

  localparam logic [1:0] STONES_PER_TURN   = 2'd2;
  localparam logic [1:0] FIRST_TURN_STONES = 2'd1;

endpackage

// File: rtl/cursor_controller_axis_stepper.sv
// One cursor axis: coordinate register reset to the board centre, stepped by
// inc/dec pulses. Saturates at the edges unless CURSOR_WRAP_EN is defined.
module axis_stepper
  import connect6_pkg::*;
#(
  parameter int unsigned BOARD_SIZE = DEFAULT_BOARD_SIZE,
  parameter int unsigned COORD_W    = DEFAULT_COORD_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               enable_i,
  output logic [COORD_W-1:0] coord_o
);

  localparam logic [COORD_W-1:0] MAX_COORD = COORD_W'(BOARD_SIZE - 1);
  localparam logic [COORD_W-1:0] CENTRE    = COORD_W'(BOARD_SIZE / 2);
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);

`ifdef CURSOR_WRAP_EN
  localparam logic [COORD_W-1:0] EDGE_INC = '0;
  localparam logic [COORD_W-1:0] EDGE_DEC = MAX_COORD;
`else
  localparam logic [COORD_W-1:0] EDGE_INC = MAX_COORD;
  localparam logic [COORD_W-1:0] EDGE_DEC = '0;
`endif

  logic [COORD_W-1:0] coord_q, coord_d;

  // Opposing pulses in the same cycle cancel out.
  always_comb begin
    coord_d = coord_q;
    if (enable_i && (inc_i != dec_i)) begin
      if (inc_i) begin
        coord_d = (coord_q == MAX_COORD) ? EDGE_INC : coord_q + ONE;
      end else begin
        coord_d = (coord_q == '0) ? EDGE_DEC : coord_q - ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      coord_q <= CENTRE;
    end else begin
      coord_q <= coord_d;
    end
  end

  assign coord_o = coord_q;

endmodule

// File: rtl/cursor_controller.sv
// Connect Six cursor and placement controller: key pulses move the cursor,
// placements go to board memory over req/ack, turn order is tracked here.
// Build option: CURSOR_WRAP_EN makes the cursor wrap at board edges.
module cursor_controller
  import connect6_pkg::*;
#(
  parameter int unsigned BOARD_SIZE = DEFAULT_BOARD_SIZE,
  parameter int unsigned COORD_W    = DEFAULT_COORD_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               left_pressed,
  input  logic               right_pressed,
  input  logic               up_pressed,
  input  logic               down_pressed,
  input  logic               place_pressed,
  input  logic               cell_occupied,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               wr_req,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic               wr_player,
  input  logic               wr_ack,
  output logic               current_player,
  output logic [1:0]         stones_left,
  output logic               place_rejected
);

  state_e             state_q;
  logic               wr_req_q;
  logic [COORD_W-1:0] wr_x_q, wr_y_q;
  logic               wr_player_q;
  logic               player_q;
  logic [1:0]         stones_q;
  logic               rejected_q;
  logic               move_en;

  // A placement request in the same cycle swallows any move pulses.
  assign move_en = (state_q == IDLE) && !place_pressed;

  axis_stepper #(
    .BOARD_SIZE (BOARD_SIZE),
    .COORD_W    (COORD_W)
  ) u_x_axis (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .inc_i    (right_pressed),
    .dec_i    (left_pressed),
    .enable_i (move_en),
    .coord_o  (cursor_x)
  );

  axis_stepper #(
    .BOARD_SIZE (BOARD_SIZE),
    .COORD_W    (COORD_W)
  ) u_y_axis (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .inc_i    (down_pressed),
    .dec_i    (up_pressed),
    .enable_i (move_en),
    .coord_o  (cursor_y)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      wr_req_q    <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_player_q <= PLAYER_BLACK;
      player_q    <= PLAYER_BLACK;
      stones_q    <= FIRST_TURN_STONES;
      rejected_q  <= 1'b0;
    end else begin
      rejected_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (place_pressed) begin
            if (cell_occupied) begin
              rejected_q <= 1'b1;
            end else begin
              wr_req_q    <= 1'b1;
              wr_x_q      <= cursor_x;
              wr_y_q      <= cursor_y;
              wr_player_q <= player_q;
              state_q     <= WRITE;
            end
          end
        end
        WRITE: begin
          if (wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= IDLE;
            // Last stone of the turn hands over to the other player.
            if (stones_q == FIRST_TURN_STONES) begin
              player_q <= ~player_q;
              stones_q <= STONES_PER_TURN;
            end else begin
              stones_q <= FIRST_TURN_STONES;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_req         = wr_req_q;
  assign wr_x           = wr_x_q;
  assign wr_y           = wr_y_q;
  assign wr_player      = wr_player_q;
  assign current_player = player_q;
  assign stones_left    = stones_q;
  assign place_rejected = rejected_q;

endmodule
